// File: rtl/maxpool2x2_stream_if.sv
// maxpool2x2_stream_if
//   Stream and control bundle for the 2x2 max-pool stage.
//   master modport: the side that feeds pixels and issues start (upstream / test driver).
//   slave modport : the pooling block itself.
//   Signals:
//     start     - one-cycle pulse, arms a new frame
//     in_valid  - in_data carries a pixel this cycle
//     in_data   - signed conv result, raster order
//     out_valid - one-cycle pulse, out_data/out_addr valid
//     out_data  - signed pooled maximum
//     out_addr  - pooled pixel index, row*(IN_W/2)+col
//     busy      - high while a frame is being consumed
//     done      - one-cycle pulse after the final pooled output
interface maxpool2x2_stream_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 8
);
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          busy;
    logic          done;

    modport master (
        output start, in_valid, in_data,
        input  out_valid, out_data, out_addr, busy, done
    );

    modport slave (
        input  start, in_valid, in_data,
        output out_valid, out_data, out_addr, busy, done
    );
endinterface

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream
//   2x2 stride-2 signed max-pool over a raster-order pixel stream. Only half a line of
//   partial maxima is stored; no frame buffer. Odd trailing rows/columns are consumed
//   and dropped (floor pooling).
//   Ports:
//     clk - rising-edge clock
//     rst - asynchronous active-low reset
//     bus - maxpool2x2_stream_if.slave (start/in_* inputs, out_*/busy/done outputs)
//   Optional build macro:
//     MAXPOOL_RELU_EN - clamp negative pooled maxima to zero at the output register.
module maxpool2x2_stream #(
    parameter int unsigned IN_H = 26,
    parameter int unsigned IN_W = 26,
    parameter int unsigned DW   = 8,
    parameter int unsigned AW   = 8
) (
    input logic                clk,
    input logic                rst,
    maxpool2x2_stream_if.slave bus
);
    localparam int unsigned RW      = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int unsigned CW      = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int unsigned OutH    = IN_H / 2;
    localparam int unsigned OutW    = IN_W / 2;
    localparam int unsigned RowLim  = OutH * 2;
    localparam int unsigned ColLim  = OutW * 2;
    localparam int unsigned LbDepth = (OutW > 0) ? OutW : 1;
    localparam int unsigned LbAw    = (LbDepth > 1) ? $clog2(LbDepth) : 1;

    localparam logic [AW-1:0] LastAddr = AW'(OutH * OutW - 1);
    localparam logic [RW-1:0] RowMax   = RW'(IN_H - 1);
    localparam logic [CW-1:0] ColMax   = CW'(IN_W - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] out_fn(input logic signed [DW-1:0] v);
`ifdef MAXPOOL_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    state_e                state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CW-1:0]         col_q, col_d;
    logic signed [DW-1:0]  hold_q, hold_d;
    logic                  out_valid_q, out_valid_d;
    logic [DW-1:0]         out_data_q, out_data_d;
    logic [AW-1:0]         out_addr_q, out_addr_d;
    logic                  done_q, done_d;
    // Last pixel of the frame was accepted; leave RUN on the following cycle.
    logic                  fin_q, fin_d;

    logic signed [DW-1:0]  lb_q [LbDepth];
    logic                  lb_we;
    logic signed [DW-1:0]  lb_wdata;
    logic [LbAw-1:0]       lb_idx;
    logic signed [DW-1:0]  lb_rd;
    logic signed [DW-1:0]  din;
    logic                  accept;
    logic                  in_win;

    assign din    = bus.in_data;
    assign lb_idx = LbAw'(col_q >> 1);
    assign lb_rd  = lb_q[lb_idx];
    assign accept = bus.in_valid && (state_q == StRun) && !fin_q;
    // Trailing odd row/column pixels fall outside every pooling window.
    assign in_win = (32'(row_q) < RowLim) && (32'(col_q) < ColLim);

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        hold_d      = hold_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        fin_d       = 1'b0;
        lb_we       = 1'b0;
        lb_wdata    = '0;

        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun:   if (fin_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Address advances after each pulse but parks on the final index.
        if (out_valid_q && (out_addr_q != LastAddr)) begin
            out_addr_d = out_addr_q + 1'b1;
        end

        if (accept) begin
            if (col_q == ColMax) begin
                col_d = '0;
                row_d = (row_q == RowMax) ? '0 : row_q + 1'b1;
                fin_d = (row_q == RowMax);
            end else begin
                col_d = col_q + 1'b1;
            end

            if (in_win) begin
                unique case ({row_q[0], col_q[0]})
                    2'b00: hold_d = din;
                    2'b01: begin
                        lb_we    = 1'b1;
                        lb_wdata = smax(hold_q, din);
                    end
                    2'b10: hold_d = smax(lb_rd, din);
                    2'b11: begin
                        out_data_d  = out_fn(smax(hold_q, din));
                        out_valid_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        // start from any state (re)arms the frame; an aborted frame never reports done.
        if (bus.start) begin
            state_d     = StRun;
            row_d       = '0;
            col_d       = '0;
            hold_d      = '0;
            out_addr_d  = '0;
            out_valid_d = 1'b0;
            fin_d       = 1'b0;
            lb_we       = 1'b0;
        end

        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            row_q       <= '0;
            col_q       <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            done_q      <= 1'b0;
            fin_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            done_q      <= done_d;
            fin_q       <= fin_d;
        end
    end

    // Line buffer needs no reset: every entry is written before it is read in a frame.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb_q[lb_idx] <= lb_wdata;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.busy      = (state_q == StRun);
    assign bus.done      = done_q;
endmodule

// File: doc/maxpool2x2_stream.md
Name: maxpool2x2_stream

Overview:
- 2x2, stride-2 signed max-pool stage sitting directly downstream of the 3x3 convolution engine.
- Consumes the conv result stream in raster order, one pixel per valid beat: 26x26 for a 28x28 input image with a 3x3 kernel.
- Emits a 13x13 pooled feature map, with a linear write address for the next layer's buffer RAM.
- Uses a half-width line buffer; no frame storage.

Parameters:
- IN_H, 26, input feature-map rows.
- IN_W, 26, input feature-map columns.
- DW, 8, pixel width; two's-complement signed.
- AW, 8, output address width; must satisfy 2^AW >= (IN_H/2)*(IN_W/2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; arms the block for a new frame.
- in_valid  in  1  in_data valid this cycle.
- in_data  in  DW  signed conv result, raster order.
- out_valid  out  1  one-cycle pulse; out_data/out_addr valid.
- out_data  out  DW  signed pooled maximum.
- out_addr  out  AW  pooled pixel index, row*(IN_W/2)+col.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse after the final pooled output.

Behaviour:
- Reset (rst=0, async): state=IDLE; out_valid=0, out_data=0, out_addr=0, busy=0, done=0; row/col counters=0; hold register=0. Line buffer contents are don't-care.
- States: IDLE -> RUN on start. RUN -> DONE on the cycle the final pooled output is produced. DONE -> IDLE after one cycle, with done=1 in DONE.
- start in RUN or DONE restarts the frame: counters clear, next state is RUN, and no done is issued for the aborted frame.
- in_valid outside RUN is ignored. No backpressure: every valid beat in RUN is consumed.
- Counters col (0..IN_W-1) and row (0..IN_H-1) advance on each accepted beat. col wraps to 0 and increments row.
- Even row, even col: hold <= in_data.
- Even row, odd col: linebuf[col>>1] <= smax(hold, in_data).
- Odd row, even col: hold <= smax(linebuf[col>>1], in_data).
- Odd row, odd col: out_data <= smax(hold, in_data); out_valid pulses the next cycle; out_addr holds the current output index, then increments after the pulse.
- Latency: out_valid is asserted exactly 1 cycle after the beat carrying the window's bottom-right pixel.
- smax is a signed comparison; ties select either operand (values are equal).
- Odd IN_W or IN_H: the trailing column/row is consumed but ignored (floor pooling). The frame ends when the last pixel of row IN_H-1 is accepted.
- out_addr after a frame: stays at (IN_H/2)*(IN_W/2)-1 until the next start, which clears it to 0.
- Gaps in in_valid are allowed anywhere; state holds.
- Reset mid-frame: immediate return to reset values; no partial output.

Optional Feature:
- Macro MAXPOOL_RELU_EN.
- Defined: a fused ReLU is applied at the output register: out_data = (max<0) ? 0 : max. Output timing is unchanged.
- Undefined: the raw signed maximum is output, and negative values pass through.

Test Plan:
- Ramp: start, then 676 beats with in_data = (r*26+c)%128 (positive). Required: 169 out_valid pulses; out at addr 0 = 27; out at addr 1 = 29; done one cycle after the addr-168 pulse; busy low afterwards.
- Signed: a window containing -5, -3, -128, -1 -> out_data = -1 (8'hFF); with MAXPOOL_RELU_EN -> 0.
- Bubbles: the ramp frame with in_valid toggling 1/0 every cycle. Required: identical data/addr sequence; each pulse lands 1 cycle after its bottom-right beat.
- Restart: start, 300 beats, then start again, then a full frame. Required: no done for the first frame; the second frame's addresses run 0..168.
- Reset mid-frame: rst=0 after 100 beats. Required: all outputs 0 at once, state IDLE; in_valid beats are ignored until the next start.
- Odd size (IN_H=IN_W=5, values 1..25): required outputs 7, 9, 17, 19 at addr 0..3; column 4 and row 4 ignored; done after addr 3.
